mdu_divider: RTL and testbench



---
 rtl/mdu_divider_pkg.sv | 15 +
 rtl/mdu_divider_if.sv | 24 ++
 rtl/mdu_divider_sign_abs.sv | 12 +
 rtl/mdu_divider.sv | 141 ++++++++++++++
 tb/tb_mdu_divider.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/mdu_divider_pkg.sv
// Shared definitions for the EXE-stage divider: FSM states and fixed constants.
// Optional feature macro used by the divider: DIV_EARLY_EXIT_EN.
package mdu_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } DivState;

    localparam int unsigned DIV_ITERS  = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_divider_if.sv
// EXE <-> divider handshake: request/operands from EXE, busy/finish/results back.
interface mdu_divider_if;

    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        div_cancel;
    logic        div_busy;
    logic        div_finish;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output div_start, div_signed, dividend, divisor, div_cancel,
        input  div_busy, div_finish, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, dividend, divisor, div_cancel,
        output div_busy, div_finish, quotient, remainder
    );

endinterface

// File: rtl/mdu_divider_sign_abs.sv
// Combinational conditional negate; with neg = sign bit it yields the absolute value.
module div_sign_abs (
    input  logic [31:0] value,
    input  logic        neg,
    output logic [31:0] result
);

    always_comb begin
        result = neg ? (~value + 32'd1) : value;
    end

endmodule

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring 32-bit divider (DIV/DIVU) for the EXE multiply/divide unit.
// Define DIV_EARLY_EXIT_EN to finish trivial divides one cycle after start.
module mdu_divider
    import mdu_divider_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mdu_divider_if.slave  div_bus
);

    DivState     state;
    logic [4:0]  cnt;
    logic [63:0] work;
    logic [31:0] abs_b;
    logic        sign_q;
    logic        sign_r;
    logic        div_zero;

    logic        busy_r;
    logic        finish_r;
    logic [31:0] quotient_r;
    logic [31:0] remainder_r;

    logic [31:0] abs_a_in;
    logic [31:0] abs_b_in;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [63:0] shifted;
    logic [32:0] trial;

    div_sign_abs u_abs_a (
        .value  (div_bus.dividend),
        .neg    (div_bus.div_signed & div_bus.dividend[31]),
        .result (abs_a_in)
    );

    div_sign_abs u_abs_b (
        .value  (div_bus.divisor),
        .neg    (div_bus.div_signed & div_bus.divisor[31]),
        .result (abs_b_in)
    );

    div_sign_abs u_fix_q (
        .value  (work[31:0]),
        .neg    (sign_q),
        .result (q_fix)
    );

    div_sign_abs u_fix_r (
        .value  (work[63:32]),
        .neg    (sign_r),
        .result (r_fix)
    );

    always_comb begin
        shifted = {work[62:0], 1'b0};
        trial   = {1'b0, shifted[63:32]} - {1'b0, abs_b};
    end

`ifdef DIV_EARLY_EXIT_EN
    logic early_exit;
    assign early_exit = (div_bus.divisor == '0) || (abs_a_in < abs_b_in) ||
                        (div_bus.dividend == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            work        <= '0;
            abs_b       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            div_zero    <= 1'b0;
            busy_r      <= 1'b0;
            finish_r    <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else if (div_bus.div_cancel) begin
            state    <= DIV_IDLE;
            busy_r   <= 1'b0;
            finish_r <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    finish_r <= 1'b0;
                    if (div_bus.div_start) begin
                        work     <= {32'b0, abs_a_in};
                        abs_b    <= abs_b_in;
                        sign_q   <= div_bus.div_signed & (div_bus.dividend[31] ^ div_bus.divisor[31]);
                        sign_r   <= div_bus.div_signed & div_bus.dividend[31];
                        div_zero <= (div_bus.divisor == '0);
                        cnt      <= 5'(DIV_ITERS - 1);
                        busy_r   <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
                        if (early_exit) begin
                            quotient_r  <= (div_bus.divisor == '0) ? DIV_ZERO_Q : '0;
                            remainder_r <= div_bus.dividend;
                            finish_r    <= 1'b1;
                            state       <= DIV_DONE;
                        end else begin
                            state <= DIV_CALC;
                        end
`else
                        state <= DIV_CALC;
`endif
                    end
                end
                DIV_CALC: begin
                    work <= trial[32] ? shifted : {trial[31:0], shifted[31:1], 1'b1};
                    cnt  <= cnt - 5'd1;
                    if (cnt == '0) begin
                        state <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    // With a zero divisor the upper half ends up holding |a|, so the
                    // normal sign fix already restores the dividend as remainder.
                    quotient_r  <= div_zero ? DIV_ZERO_Q : q_fix;
                    remainder_r <= r_fix;
                    finish_r    <= 1'b1;
                    state       <= DIV_DONE;
                end
                DIV_DONE: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state    <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign div_bus.div_busy   = busy_r;
    assign div_bus.div_finish = finish_r;
    assign div_bus.quotient   = quotient_r;
    assign div_bus.remainder  = remainder_r;

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: directed cases plus random divides against an arithmetic model.
module tb_mdu_divider;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    logic [31:0] last_q;
    logic [31:0] last_r;

    mdu_divider_if bus ();

    mdu_divider dut (
        .clk     (clk),
        .rst     (rst),
        .div_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of DIV/DIVU, including the zero-divisor and overflow rules.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, abs_a, abs_b;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        abs_a = (sa < 0) ? -sa : sa;
        abs_b = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
`ifdef DIV_EARLY_EXIT_EN
        lat = (b == 32'd0 || abs_a < abs_b || a == 32'd0) ? 1 : 34;
`else
        lat = 34;
`endif
    endtask

    // Called at a negedge with the divider idle; leaves at the negedge after busy drops.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input string tag);
        logic [31:0] eq, er;
        int          elat;
        int          cyc;
        ref_div(a, b, sgn, eq, er, elat);
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        @(negedge clk);
        bus.div_start = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        cyc = 1;
        check({tag, "_busy_c1"}, 32'(bus.div_busy), 32'd1);
        while (bus.div_finish !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(elat));
        check({tag, "_quot"}, bus.quotient, eq);
        check({tag, "_rem"}, bus.remainder, er);
        @(negedge clk);
        check({tag, "_finish_pulse"}, 32'(bus.div_finish), 32'd0);
        check({tag, "_busy_drop"}, 32'(bus.div_busy), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    initial begin
        logic        saw_finish;
        logic [31:0] ra, rb;
        tests  = 0;
        failed = 0;
        last_q = 32'd0;
        last_r = 32'd0;
        rst            = 1'b1;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd0;
        bus.divisor    = 32'd0;
        bus.div_cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.div_busy), 32'd0);
        check("reset_finish", 32'(bus.div_finish), 32'd0);
        check("reset_quot", bus.quotient, 32'd0);
        check("reset_rem", bus.remainder, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b0, "u100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        run_div(32'd5, 32'd0, 1'b0, "u5_0");
        run_div(32'd5, 32'd0, 1'b1, "s5_0");
        run_div(32'hFFFF_FFFB, 32'd0, 1'b1, "s_m5_0");
        run_div(32'd3, 32'd10, 1'b0, "u3_10");
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");

        // Cancel during CALC cycle 10
        bus.div_start  = 1'b1;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd9;
        bus.divisor    = 32'd3;
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (9) @(negedge clk);
        bus.div_cancel = 1'b1;
        @(negedge clk);
        bus.div_cancel = 1'b0;
        check("cancel_busy", 32'(bus.div_busy), 32'd0);
        saw_finish = 1'b0;
        repeat (40) begin
            if (bus.div_finish === 1'b1) saw_finish = 1'b1;
            @(negedge clk);
        end
        check("cancel_no_finish", 32'(saw_finish), 32'd0);
        check("cancel_quot_held", bus.quotient, last_q);
        check("cancel_rem_held", bus.remainder, last_r);
        run_div(32'd9, 32'd3, 1'b0, "restart9_3");

        // Start and cancel together
        bus.div_start  = 1'b1;
        bus.div_cancel = 1'b1;
        bus.dividend   = 32'd50;
        bus.divisor    = 32'd5;
        @(negedge clk);
        bus.div_start  = 1'b0;
        bus.div_cancel = 1'b0;
        check("startcancel_busy", 32'(bus.div_busy), 32'd0);
        saw_finish = 1'b0;
        repeat (40) begin
            if (bus.div_finish === 1'b1 || bus.div_busy === 1'b1) saw_finish = 1'b1;
            @(negedge clk);
        end
        check("startcancel_idle", 32'(saw_finish), 32'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = (i % 5 == 0) ? 32'd0 : ($urandom | 32'h8000_0000);
                default: rb = ra >> $urandom_range(0, 31);
            endcase
            if (i % 7 == 3) ra = $urandom_range(0, 15);
            run_div(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
